// File: rtl/psum_accum.sv
// Realigns the diagonally skewed psum columns from the systolic array, accumulates ACC_DEPTH rows
// over K-tiles, then drains them over valid/ready. Define MMU_ACC_SAT_EN for saturating adds.
module psum_accum #(
   parameter int SYS_COL    = 16,
   parameter int DATA_WIDTH = 16,
   parameter int ACC_DEPTH  = 16,
   parameter int GUARD      = 4,
   localparam int PSUM_W    = 2 * DATA_WIDTH,
   localparam int ACC_W     = PSUM_W + GUARD,
   localparam int PTR_W     = $clog2(ACC_DEPTH)
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic [SYS_COL*PSUM_W-1:0]  psum_in,
   input  logic                       psum_vld,
   input  logic                       psum_first,
   input  logic                       psum_last,
   output logic                       busy,
   output logic                       err,
   output logic [SYS_COL*ACC_W-1:0]   out_data,
   output logic                       out_vld,
   input  logic                       out_rdy,
   output logic [PTR_W-1:0]           out_row
);

   typedef enum logic {ACCUM, DRAIN} state_t;

   localparam logic [PTR_W-1:0] LAST_ROW = PTR_W'(ACC_DEPTH - 1);
   localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

   state_t                     state_q, state_d;
   logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
   logic                       out_vld_q, out_vld_d;
   logic                       err_q, err_d;
   logic                       bank_we;
   logic [SYS_COL*ACC_W-1:0]   bank_q [ACC_DEPTH];
   logic [SYS_COL*ACC_W-1:0]   row_d;
   logic [SYS_COL*ACC_W-1:0]   old_row;
   logic [SYS_COL*PSUM_W-1:0]  a_data;
   logic [2:0]                 ctl_q [SYS_COL-1];
   logic                       a_vld, a_first, a_last;
   logic [ACC_W-1:0]           ext_lane, old_lane;
   logic [ACC_W:0]             sum_lane;

   // Lane j arrives j cycles after lane 0, so it waits SYS_COL-1-j cycles to line up (SYS_COL >= 2).
   for (genvar j = 0; j < SYS_COL; j++) begin : g_lane
      localparam int D = SYS_COL - 1 - j;
      if (D == 0) begin : g_direct
         assign a_data[j*PSUM_W +: PSUM_W] = psum_in[j*PSUM_W +: PSUM_W];
      end else begin : g_dly
         logic [PSUM_W-1:0] dly_q [D];
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               for (int k = 0; k < D; k++) dly_q[k] <= '0;
            end else begin
               dly_q[0] <= psum_in[j*PSUM_W +: PSUM_W];
               for (int k = 1; k < D; k++) dly_q[k] <= dly_q[k-1];
            end
         end
         assign a_data[j*PSUM_W +: PSUM_W] = dly_q[D-1];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < SYS_COL - 1; k++) ctl_q[k] <= '0;
      end else begin
         ctl_q[0] <= {psum_vld, psum_first, psum_last};
         for (int k = 1; k < SYS_COL - 1; k++) ctl_q[k] <= ctl_q[k-1];
      end
   end

   assign {a_vld, a_first, a_last} = ctl_q[SYS_COL-2];
   assign old_row = bank_q[wr_ptr_q];

   always_comb begin
      row_d    = '0;
      ext_lane = '0;
      old_lane = '0;
      sum_lane = '0;
      for (int l = 0; l < SYS_COL; l++) begin
         ext_lane = {{GUARD{a_data[l*PSUM_W + PSUM_W - 1]}}, a_data[l*PSUM_W +: PSUM_W]};
         old_lane = old_row[l*ACC_W +: ACC_W];
         sum_lane = {old_lane[ACC_W-1], old_lane} + {ext_lane[ACC_W-1], ext_lane};
         if (a_first) begin
            row_d[l*ACC_W +: ACC_W] = ext_lane;
         end else begin
`ifdef MMU_ACC_SAT_EN
            // Differing top two bits of the widened sum mean the lane left the ACC_W range.
            if (sum_lane[ACC_W] != sum_lane[ACC_W-1])
               row_d[l*ACC_W +: ACC_W] = sum_lane[ACC_W] ? ACC_MIN : ACC_MAX;
            else
               row_d[l*ACC_W +: ACC_W] = sum_lane[ACC_W-1:0];
`else
            row_d[l*ACC_W +: ACC_W] = sum_lane[ACC_W-1:0];
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < ACC_DEPTH; k++) bank_q[k] <= '0;
      end else if (bank_we) begin
         bank_q[wr_ptr_q] <= row_d;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= ACCUM;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         out_vld_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         out_vld_q <= out_vld_d;
         err_q     <= err_d;
      end
   end

   // Rows that align while draining are dropped; the bank is only ever written in ACCUM.
   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      out_vld_d = out_vld_q;
      err_d     = err_q;
      bank_we   = 1'b0;
      if (psum_vld && state_q == DRAIN) err_d = 1'b1;
      case (state_q)
         ACCUM: begin
            if (a_vld) begin
               bank_we  = 1'b1;
               wr_ptr_d = wr_ptr_q + 1'b1;
               if (a_last && wr_ptr_q == LAST_ROW) begin
                  state_d  = DRAIN;
                  rd_ptr_d = '0;
               end
            end
         end
         DRAIN: begin
            if (a_vld) err_d = 1'b1;
            if (!out_vld_q) begin
               out_vld_d = 1'b1;
            end else if (out_rdy) begin
               if (rd_ptr_q == LAST_ROW) begin
                  out_vld_d = 1'b0;
                  state_d   = ACCUM;
                  wr_ptr_d  = '0;
                  rd_ptr_d  = '0;
               end else begin
                  rd_ptr_d = rd_ptr_q + 1'b1;
               end
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   assign busy     = (state_q == DRAIN);
   assign err      = err_q;
   assign out_vld  = out_vld_q;
   assign out_row  = rd_ptr_q;
   assign out_data = bank_q[rd_ptr_q];

endmodule

// File: tb/tb_psum_accum.sv
// Directed bench for psum_accum: skew, multi-pass accumulation, backpressure, misuse, overflow, reset.
module tb_psum_accum;

   localparam int SYS_COL    = 16;
   localparam int DATA_WIDTH = 16;
   localparam int ACC_DEPTH  = 16;
   localparam int GUARD      = 4;
   localparam int PSUM_W     = 2 * DATA_WIDTH;
   localparam int ACC_W      = PSUM_W + GUARD;
   localparam int PTR_W      = $clog2(ACC_DEPTH);
   localparam int ROW_W      = SYS_COL * ACC_W;
   localparam longint ACC_MAX = (longint'(1) << (ACC_W - 1)) - 1;
   localparam longint ACC_MIN = -(longint'(1) << (ACC_W - 1));

   logic                      clk = 1'b0;
   logic                      rstn;
   logic [SYS_COL*PSUM_W-1:0] psum_in;
   logic                      psum_vld, psum_first, psum_last;
   logic                      busy, err;
   logic [ROW_W-1:0]          out_data;
   logic                      out_vld, out_rdy;
   logic [PTR_W-1:0]          out_row;

   int   checks = 0;
   int   errors = 0;
   logic busyBeforeWrite;
   logic [ROW_W-1:0] firstRowSeen;

   psum_accum #(
      .SYS_COL(SYS_COL), .DATA_WIDTH(DATA_WIDTH), .ACC_DEPTH(ACC_DEPTH), .GUARD(GUARD)
   ) dut (
      .clk(clk), .rstn(rstn), .psum_in(psum_in), .psum_vld(psum_vld),
      .psum_first(psum_first), .psum_last(psum_last), .busy(busy), .err(err),
      .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy), .out_row(out_row)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [ROW_W-1:0] actual,
                              input logic [ROW_W-1:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s got %0h expected %0h", tag, actual, expected);
      end
   endtask

   // Mode 0: lane j = j+1; 1: all 5; 2: 0x7FFFFFFF; 3: signed (r-j)*1000.
   function automatic logic [PSUM_W-1:0] stim(input int mode, input int r, input int j);
      case (mode)
         0:       return PSUM_W'(j + 1);
         1:       return PSUM_W'(5);
         2:       return 32'h7FFF_FFFF;
         3:       return PSUM_W'((r - j) * 1000);
         default: return '0;
      endcase
   endfunction

   function automatic logic [ACC_W-1:0] expLane(input int mode, input int r, input int j,
                                                input int passes);
      longint v, acc;
      v   = longint'($signed(stim(mode, r, j)));
      acc = v;
      for (int p = 1; p < passes; p++) begin
         acc = acc + v;
`ifdef MMU_ACC_SAT_EN
         if (acc > ACC_MAX) acc = ACC_MAX;
         else if (acc < ACC_MIN) acc = ACC_MIN;
`endif
      end
      return acc[ACC_W-1:0];
   endfunction

   function automatic logic [ROW_W-1:0] expRow(input int mode, input int r, input int passes);
      logic [ROW_W-1:0] row;
      row = '0;
      for (int j = 0; j < SYS_COL; j++) row[j*ACC_W +: ACC_W] = expLane(mode, r, j, passes);
      return row;
   endfunction

   // Drives one pass of ACC_DEPTH rows with the array's diagonal skew; returns just after
   // the edge that writes the last row.
   task automatic applyStimulus(input int mode, input bit first, input bit last);
      for (int c = 0; c < ACC_DEPTH + SYS_COL - 1; c++) begin
         psum_vld   = (c < ACC_DEPTH);
         psum_first = (c < ACC_DEPTH) && first;
         psum_last  = (c < ACC_DEPTH) && last;
         for (int j = 0; j < SYS_COL; j++) begin
            if (c - j >= 0 && c - j < ACC_DEPTH)
               psum_in[j*PSUM_W +: PSUM_W] = stim(mode, c - j, j);
            else
               psum_in[j*PSUM_W +: PSUM_W] = '0;
         end
         @(posedge clk); #1;
         if (c == ACC_DEPTH + SYS_COL - 3) busyBeforeWrite = busy;
      end
      psum_vld   = 1'b0;
      psum_first = 1'b0;
      psum_last  = 1'b0;
      psum_in    = '0;
   endtask

   // Consumes rowsToTake rows; rdySel 1 gives out_rdy = 1,0,0,1 repeating.
   task automatic drainCheck(input int mode, input int passes, input int rdySel,
                             input int injectAt, input int rowsToTake, input string tag);
      int   idx = 0;
      int   cyc = 0;
      logic [3:0] rdyPat = 4'b1001;
      logic rdy;
      while (idx < rowsToTake && cyc < 400) begin
         rdy     = (rdySel == 0) ? 1'b1 : rdyPat[cyc % 4];
         out_rdy = rdy;
         if (cyc == injectAt) begin
            psum_vld = 1'b1; psum_first = 1'b1; psum_last = 1'b1; psum_in = '1;
         end else begin
            psum_vld = 1'b0; psum_first = 1'b0; psum_last = 1'b0; psum_in = '0;
         end
         if (out_vld) begin
            checkOutput({tag, "_row"}, ROW_W'(out_row), ROW_W'(idx));
            checkOutput({tag, "_data"}, out_data, expRow(mode, idx, passes));
            if (idx == 0) firstRowSeen = out_data;
            if (rdy) idx++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      if (idx < rowsToTake) checkOutput({tag, "_timeout"}, ROW_W'(idx), ROW_W'(rowsToTake));
      out_rdy  = 1'b0;
      psum_vld = 1'b0;
      psum_in  = '0;
      if (rowsToTake == ACC_DEPTH) begin
         checkOutput({tag, "_busy_end"}, ROW_W'(busy), ROW_W'(0));
         checkOutput({tag, "_vld_end"}, ROW_W'(out_vld), ROW_W'(0));
      end
   endtask

   initial begin
      rstn = 1'b0; psum_in = '0; psum_vld = 1'b0; psum_first = 1'b0; psum_last = 1'b0;
      out_rdy = 1'b0; busyBeforeWrite = 1'b0; firstRowSeen = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_busy", ROW_W'(busy), ROW_W'(0));
      checkOutput("rst_err", ROW_W'(err), ROW_W'(0));
      checkOutput("rst_vld", ROW_W'(out_vld), ROW_W'(0));
      checkOutput("rst_row", ROW_W'(out_row), ROW_W'(0));
      checkOutput("rst_data", out_data, ROW_W'(0));
      rstn = 1'b1;
      @(posedge clk); #1;

      $display("[TB] test 1: skew realignment");
      applyStimulus(0, 1'b1, 1'b1);
      checkOutput("t1_busy_pre", ROW_W'(busyBeforeWrite), ROW_W'(0));
      checkOutput("t1_busy_entry", ROW_W'(busy), ROW_W'(1));
      checkOutput("t1_vld_entry", ROW_W'(out_vld), ROW_W'(0));
      drainCheck(0, 1, 0, -1, ACC_DEPTH, "t1");
      checkOutput("t1_lane15", ROW_W'(firstRowSeen[15*ACC_W +: ACC_W]), ROW_W'(16));

      $display("[TB] test 2: three-pass accumulate");
      applyStimulus(1, 1'b1, 1'b0);
      checkOutput("t2_busy_mid", ROW_W'(busy), ROW_W'(0));
      applyStimulus(1, 1'b0, 1'b0);
      applyStimulus(1, 1'b0, 1'b1);
      drainCheck(1, 3, 0, -1, ACC_DEPTH, "t2");
      checkOutput("t2_lane0", ROW_W'(firstRowSeen[0 +: ACC_W]), ROW_W'(15));

      $display("[TB] test 3: backpressure");
      applyStimulus(3, 1'b1, 1'b1);
      drainCheck(3, 1, 1, -1, ACC_DEPTH, "t3");
      checkOutput("t3_lane15", firstRowSeen[15*ACC_W +: ACC_W], ROW_W'(36'hF_FFFF_C568));

      $display("[TB] test 4: psum_vld during drain");
      checkOutput("t4_err_pre", ROW_W'(err), ROW_W'(0));
      applyStimulus(0, 1'b1, 1'b1);
      drainCheck(0, 1, 1, 3, ACC_DEPTH, "t4");
      checkOutput("t4_err", ROW_W'(err), ROW_W'(1));

      $display("[TB] test 5: overflow over 17 passes");
      for (int p = 0; p < 17; p++) applyStimulus(2, p == 0, p == 16);
      drainCheck(2, 17, 0, -1, ACC_DEPTH, "t5");
`ifdef MMU_ACC_SAT_EN
      checkOutput("t5_lane0", ROW_W'(firstRowSeen[0 +: ACC_W]), ROW_W'(36'h7_FFFF_FFFF));
`else
      checkOutput("t5_lane0", ROW_W'(firstRowSeen[0 +: ACC_W]), ROW_W'(36'h8_7FFF_FFEF));
`endif
      checkOutput("t5_err_held", ROW_W'(err), ROW_W'(1));

      $display("[TB] test 6: reset mid-drain");
      applyStimulus(3, 1'b1, 1'b1);
      drainCheck(3, 1, 0, -1, 7, "t6a");
      checkOutput("t6_row_pre", ROW_W'(out_row), ROW_W'(7));
      rstn = 1'b0;
      #1;
      checkOutput("t6_vld", ROW_W'(out_vld), ROW_W'(0));
      checkOutput("t6_busy", ROW_W'(busy), ROW_W'(0));
      checkOutput("t6_err", ROW_W'(err), ROW_W'(0));
      checkOutput("t6_row", ROW_W'(out_row), ROW_W'(0));
      @(posedge clk); #1;
      rstn = 1'b1;
      @(posedge clk); #1;
      applyStimulus(0, 1'b1, 1'b1);
      drainCheck(0, 1, 1, -1, ACC_DEPTH, "t6b");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
